// File: rtl/fb_pkg.sv
// fb_pkg: shared types and geometry for the frame-buffer capture path.
// Holds the capture FSM state enum, frame dimensions and pixel/address types.
package fb_pkg;

  localparam int FB_WIDTH  = 240;
  localparam int FB_HEIGHT = 320;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 17;
  localparam int PIX_W     = 16;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE
  } fb_state_t;

  localparam addr_t DEPTH_A = addr_t'(FB_DEPTH);
  localparam addr_t LAST_A  = addr_t'(FB_DEPTH - 1);

endpackage

// File: rtl/fb_port_mux.sv
// fb_port_mux: shares the single BRAM port between camera writes and reads.
// Writes win; reads see a 1-cycle address stage plus 1-cycle BRAM latency.
module fb_port_mux
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [PIX_W-1:0]  bram_din,
  output logic              bram_we,
  input  logic [PIX_W-1:0]  bram_dout
);

  addr_t  addr_q, addr_d;
  pixel_t din_q, din_d;
  logic   we_q, we_d;
  logic   rv1_q, rv1_d;
  logic   rv2_q, rv2_d;
  logic   oob1_q, oob1_d;
  logic   oob2_q, oob2_d;
  logic   rd_oob;

  assign rd_oob = (rd_addr >= DEPTH_A);
  assign rd_gnt = rd_req && !wr_en;

  // Port select: a write owns the port, otherwise a pending read takes it.
  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = 1'b0;
    rv1_d  = 1'b0;
    oob1_d = 1'b0;
    rv2_d  = rv1_q;
    oob2_d = oob1_q;
    unique case (1'b1)
      wr_en: begin
        addr_d = wr_addr;
        din_d  = wr_data;
        we_d   = 1'b1;
      end
      rd_gnt: begin
        addr_d = rd_oob ? '0 : rd_addr;
        rv1_d  = 1'b1;
        oob1_d = rd_oob;
      end
      default: ;
    endcase
  end

  // Registered port signals and the read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
      rv1_q  <= 1'b0;
      rv2_q  <= 1'b0;
      oob1_q <= 1'b0;
      oob2_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      din_q  <= din_d;
      we_q   <= we_d;
      rv1_q  <= rv1_d;
      rv2_q  <= rv2_d;
      oob1_q <= oob1_d;
      oob2_q <= oob2_d;
    end
  end

  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign bram_we   = we_q;
  assign rd_valid  = rv2_q;
  assign rd_data   = (rv2_q && !oob2_q) ? bram_dout : '0;

endmodule

// File: rtl/fb_capture_arbiter.sv
// fb_capture_arbiter: single-frame capture sequencer over a shared BRAM port.
// Define FB_DROP_COUNT_EN to add the saturating drop_count output.
module fb_capture_arbiter
  import fb_pkg::*;
(
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic              capture_start,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [PIX_W-1:0]  bram_din,
  output logic              bram_we,
  input  logic [PIX_W-1:0]  bram_dout,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pix_count,
`ifdef FB_DROP_COUNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic              short_frame
);

  fb_state_t state_q, state_d;
  addr_t     cnt_q, cnt_d;
  logic      short_q, short_d;
  logic      exit_q, exit_d;
  logic      done_q;
  logic      wr_en;
  logic      full;
  addr_t     wr_addr;

  assign wr_en   = pix_valid && (state_q == CAPTURE);
  assign wr_addr = frame_start ? '0 : cnt_q;
  assign full    = wr_en && (wr_addr == LAST_A);

  // Capture sequencing and pixel counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = short_q;
    exit_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture_start) begin
          state_d = ARM;
          cnt_d   = '0;
          short_d = 1'b0;
        end
      end
      ARM: begin
        if (frame_start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        cnt_d = wr_addr + {{(ADDR_W-1){1'b0}}, wr_en};
        if (full || frame_end) begin
          state_d = IDLE;
          exit_d  = 1'b1;
          if (!full) short_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters, and the delayed completion pulse.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      exit_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      exit_q  <= exit_d;
      done_q  <= exit_q;
    end
  end

`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  // Count pixels that arrive while no capture is in progress.
  always_comb begin
    drop_d = drop_q;
    if (state_q == IDLE && capture_start)
      drop_d = '0;
    else if (pix_valid && state_q != CAPTURE && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign pix_count   = cnt_q;
  assign short_frame = short_q;

  fb_port_mux u_mux (
    .clk       (clk_100mhz),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (pix_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .bram_dout (bram_dout)
  );

endmodule

// File: tb/tb_fb_capture_arbiter.sv
// tb_fb_capture_arbiter: scoreboard bench for the frame-buffer arbiter.
// Expected writes, reads and frame completions are queued and checked by a monitor.
module tb_fb_capture_arbiter;
  import fb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          capture_start, frame_start, frame_end, pix_valid;
  logic [15:0]   pix_data;
  logic          rd_req;
  logic [16:0]   rd_addr;
  logic          rd_gnt, rd_valid;
  logic [15:0]   rd_data;
  logic [16:0]   bram_addr;
  logic [15:0]   bram_din;
  logic          bram_we;
  logic [15:0]   bram_dout;
  logic          busy, frame_done, short_frame;
  logic [16:0]   pix_count;
`ifdef FB_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  fb_capture_arbiter dut (
    .clk_100mhz    (clk),
    .rst_n         (rst_n),
    .capture_start (capture_start),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_we       (bram_we),
    .bram_dout     (bram_dout),
    .busy          (busy),
    .frame_done    (frame_done),
    .pix_count     (pix_count),
`ifdef FB_DROP_COUNT_EN
    .drop_count    (drop_count),
`endif
    .short_frame   (short_frame)
  );

  // Read-first BRAM, one cycle latency; out-of-range reads return a marker.
  bit [15:0] mem [0:FB_DEPTH-1];
  logic [15:0] dout_q = 16'h0;
  always @(posedge clk) begin
    if (int'(bram_addr) < FB_DEPTH) begin
      dout_q <= mem[int'(bram_addr)];
      if (bram_we) mem[int'(bram_addr)] <= bram_din;
    end else begin
      dout_q <= 16'hDEAD;
    end
  end
  assign bram_dout = dout_q;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int c; int addr; int data; } wr_t;
  typedef struct { int c; int data; } rd_t;
  typedef struct { int c; int cnt; int sh; } dn_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  dn_t dn_q[$];
  bit [15:0] sb [0:FB_DEPTH-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (bram_we) begin
      if (wr_q.size() == 0) begin
        chk("stray_write", 32'(bram_addr), 32'hFFFFFFFF);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(w.c));
        chk("wr_addr", 32'(bram_addr), 32'(w.addr));
        chk("wr_data", 32'(bram_din), 32'(w.data));
      end
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        chk("stray_rd_valid", 32'(rd_data), 32'hFFFFFFFF);
      end else begin
        rd_t r;
        r = rd_q.pop_front();
        chk("rd_cycle", 32'(cyc), 32'(r.c));
        chk("rd_data", 32'(rd_data), 32'(r.data));
      end
    end
    if (frame_done) begin
      if (dn_q.size() == 0) begin
        chk("stray_frame_done", 32'(pix_count), 32'hFFFFFFFF);
      end else begin
        dn_t d;
        d = dn_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d.c));
        chk("done_pix_count", 32'(pix_count), 32'(d.cnt));
        chk("done_short", 32'(short_frame), 32'(d.sh));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int base, input int dbase,
                        input bit cap);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(dbase + i);
      if (cap) begin
        wr_q.push_back('{cyc + 1, base + i, (dbase + i) & 16'hFFFF});
        sb[base + i] = 16'(dbase + i);
      end
      step();
    end
    pix_valid = 1'b0;
  endtask

  task automatic do_read(input int a, input int exp, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    rd_req  = 1'b1;
    rd_addr = 17'(a);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rd_gnt) begin
        rd_q.push_back('{cyc + 2, exp});
        got = 1'b1;
      end else begin
        waits++;
      end
      step();
    end
    if (!got) chk("rd_grant_timeout", 32'(waits), 32'd0);
  endtask

  task automatic pulse_fe(input int cnt, input int sh);
    frame_end = 1'b1;
    dn_q.push_back('{cyc + 2, cnt, sh});
    step();
    frame_end = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    capture_start = 1'b0;
    frame_start = 1'b0;
    frame_end = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    rd_req = 1'b0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bram_we", 32'(bram_we), 0);
    chk("rst_bram_addr", 32'(bram_addr), 0);
    chk("rst_bram_din", 32'(bram_din), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pix_count", 32'(pix_count), 0);
    chk("rst_short", 32'(short_frame), 0);
    chk("rst_rd_gnt", 32'(rd_gnt), 0);
    step();
    rst_n = 1'b1;
    step();

    // capture_start together with frame_start: ARM only.
    capture_start = 1'b1;
    frame_start = 1'b1;
    step();
    capture_start = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    chk("arm_busy", 32'(busy), 1);
    step();
    stream(3, 0, 16'h5555, 1'b0);
    capture_start = 1'b1;
    step();
    capture_start = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;

    // Full frame, data = address[15:0].
    stream(FB_DEPTH, 0, 0, 1'b1);
    dn_q.push_back('{cyc + 1, FB_DEPTH, 0});
    repeat (3) step();
    @(negedge clk);
    chk("full_busy", 32'(busy), 0);
    chk("full_pix_count", 32'(pix_count), 32'(FB_DEPTH));
    chk("full_short", 32'(short_frame), 0);
    step();
    stream(2, 0, 16'h7777, 1'b0);
    step();
`ifdef FB_DROP_COUNT_EN
    @(negedge clk);
    chk("drop_count_5", 32'(drop_count), 5);
    step();
`endif

    // Back-to-back reads with no writes pending.
    do_read(FB_DEPTH - 1, int'(sb[FB_DEPTH-1]), w);
    chk("rd_wait_a", 32'(w), 0);
    do_read(1500, int'(sb[1500]), w);
    chk("rd_wait_b", 32'(w), 0);
    do_read(0, int'(sb[0]), w);
    chk("rd_wait_c", 32'(w), 0);
    rd_req = 1'b0;
    step();

    // Second capture: resync after 50 pixels, collision, short frame.
    capture_start = 1'b1;
    step();
    capture_start = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    stream(50, 0, 16'hB000, 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    stream(10, 0, 16'hA000, 1'b1);
    pix_valid = 1'b1;
    pix_data = 16'hA00A;
    wr_q.push_back('{cyc + 1, 10, 16'hA00A});
    sb[10] = 16'hA00A;
    rd_req = 1'b1;
    rd_addr = 17'd5;
    @(negedge clk);
    chk("gnt_collide", 32'(rd_gnt), 0);
    step();
    pix_valid = 1'b0;
    @(negedge clk);
    chk("gnt_after", 32'(rd_gnt), 1);
    rd_q.push_back('{cyc + 2, int'(sb[5])});
    step();
    rd_req = 1'b0;
    stream(989, 11, 16'hA00B, 1'b1);
    pulse_fe(1000, 1);
    repeat (3) step();
    @(negedge clk);
    chk("short_flag", 32'(short_frame), 1);
    chk("short_pix_count", 32'(pix_count), 1000);
    chk("short_busy", 32'(busy), 0);
    step();

    // Out-of-range reads return 0; in-range ones return the last data.
    do_read(FB_DEPTH, 0, w);
    do_read(131071, 0, w);
    do_read(0, int'(sb[0]), w);
    do_read(49, int'(sb[49]), w);
    do_read(1500, int'(sb[1500]), w);
    rd_req = 1'b0;
    step();

    // New arm clears short_frame and pix_count.
    capture_start = 1'b1;
    step();
    capture_start = 1'b0;
    @(negedge clk);
    chk("rearm_short", 32'(short_frame), 0);
    chk("rearm_pix_count", 32'(pix_count), 0);
`ifdef FB_DROP_COUNT_EN
    chk("rearm_drop", 32'(drop_count), 0);
`endif
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pulse_fe(0, 1);
    repeat (3) step();

    // Asynchronous reset in the middle of a write burst.
    capture_start = 1'b1;
    step();
    capture_start = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    stream(20, 0, 16'hC000, 1'b1);
    pix_valid = 1'b1;
    pix_data = 16'hC014;
    #1;
    chk("burst_we", 32'(bram_we), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(bram_we), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pix_count", 32'(pix_count), 0);
    wr_q.delete();
    pix_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();

    chk("wr_q_empty", 32'(wr_q.size()), 0);
    chk("rd_q_empty", 32'(rd_q.size()), 0);
    chk("dn_q_empty", 32'(dn_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_capture_arbiter.md
# fb_capture_arbiter

Frame-buffer controller between the camera pixel assembler and the single-port 76800×16 RGB565 frame-buffer BRAM (read-first, LOW_LATENCY, 1-cycle read latency). It sequences single-frame captures (arm → wait for frame start → write a full frame) and shares the one BRAM port between the camera write stream and a downstream reader (card-recognition engine). Camera writes always have priority.

## Interface
- FB_WIDTH, 240: pixels per line.
- FB_HEIGHT, 320: lines per frame.
- FB_DEPTH, FB_WIDTH*FB_HEIGHT (76800): BRAM entries.
- ADDR_W, 17: BRAM address width.
- PIX_W, 16: pixel width (RGB565).

Ports:
- clk_100mhz  in  1  system clock; all logic in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- capture_start  in  1  one-cycle pulse that arms the capture of the next frame.
- frame_start  in  1  one-cycle pulse at a synchronized vsync falling edge.
- frame_end  in  1  one-cycle pulse at a synchronized vsync rising edge.
- pix_valid  in  1  one-cycle strobe; pix_data holds an assembled pixel.
- pix_data  in  PIX_W  assembled pixel, {byte0, byte1}.
- rd_req  in  1  reader request; held until granted.
- rd_addr  in  ADDR_W  reader address; stable while rd_req is high.
- rd_gnt  out  1  combinational grant, issued in the same cycle as the request.
- rd_valid  out  1  one-cycle strobe marking rd_data valid.
- rd_data  out  PIX_W  read data.
- bram_addr  out  ADDR_W  registered BRAM address.
- bram_din  out  PIX_W  registered BRAM write data.
- bram_we  out  1  registered BRAM write enable.
- bram_dout  in  PIX_W  BRAM read data.
- busy  out  1  high while in ARM or CAPTURE.
- frame_done  out  1  one-cycle pulse when a capture completes.
- pix_count  out  ADDR_W  number of pixels written in the current or last frame.
- short_frame  out  1  sticky; set when frame_end arrives before FB_DEPTH pixels are written.

## Operation
- States: IDLE, ARM, CAPTURE.
  - IDLE → ARM on capture_start. Entering ARM clears pix_count, short_frame and the drop counter.
  - ARM → CAPTURE on frame_start. The write address resets to 0.
  - CAPTURE → IDLE when the FB_DEPTH-th pixel is written, or on frame_end, whichever comes first. frame_done pulses in the cycle after the transition.
  - frame_start in CAPTURE resynchronizes: the address and pix_count reset to 0, and the state stays CAPTURE.
  - capture_start outside IDLE is ignored.
  - capture_start and frame_start together in IDLE: go to ARM only.
- Writes:
  - pix_valid in CAPTURE writes pix_data at address pix_count, then pix_count increments.
  - pix_valid in IDLE or ARM is dropped.
  - Back-to-back pix_valid (every cycle) is accepted.
- Arbitration: rd_gnt = rd_req && !(pix_valid && state==CAPTURE). Reads are served in every state.
- Reads:
  - rd_addr ≥ FB_DEPTH is granted and returns 0.
  - A write and a read never share a cycle, so no read-first hazard arises at the port.
- pix_count saturates at FB_DEPTH. Addresses never wrap.

## Timing
- Reset values: bram_addr=0, bram_din=0, bram_we=0, rd_valid=0, rd_data=0, frame_done=0, busy=0, pix_count=0, short_frame=0, state=IDLE. rd_gnt depends only on its inputs (0 while rd_req=0).
- Write path: pix_valid in cycle N → bram_we=1 with the matching address and data in cycle N+1.
- Read path: grant in cycle N → bram_addr driven in N+1 → rd_valid=1 with rd_data in N+2. Sustained throughput is 1 read per cycle when no writes occur.
- Reset mid-capture: all state clears immediately. bram_we drops asynchronously, so no partial write is issued after rst_n falls.
- frame_done pulses in the cycle after the final write is presented on bram_we.

## Configuration
- FB_DROP_COUNT_EN defined: adds output drop_count (16 bits, saturating). It increments on every pix_valid dropped outside CAPTURE, including pixels arriving after a full frame. It clears on entry to ARM and resets to 0.
- FB_DROP_COUNT_EN undefined: the port and the counter are absent. Drop behaviour is otherwise identical.

## Structure
- Package fb_pkg holds:
  - the state enum fb_state_t {IDLE, ARM, CAPTURE};
  - FB_WIDTH, FB_HEIGHT, FB_DEPTH, ADDR_W, PIX_W;
  - typedef pixel_t (logic [PIX_W-1:0]).
- Sub-module fb_port_mux is a natural split. It holds the grant logic, the registered BRAM address/data/we, and the 2-stage rd_valid pipeline. The FSM and counters stay in the top module.

## Test plan
- Full frame: capture_start, frame_start, 76800 pix_valid with data = address[15:0] → last write at bram_addr 76799; frame_done pulses once; pix_count=76800; short_frame=0; state IDLE.
- Collision: pix_valid and rd_req(addr 5) in the same cycle during CAPTURE → rd_gnt=0 that cycle; granted the next cycle; rd_valid 2 cycles after grant with the data written at address 5.
- Short frame: frame_end after 1000 pixels → frame_done pulses; pix_count=1000; short_frame=1. A following capture_start clears short_frame.
- Resync: frame_start after 50 pixels in CAPTURE → next pixel written at address 0.
- Drops (FB_DROP_COUNT_EN): 3 pix_valid in ARM plus 2 after a full frame → drop_count=5. Without the macro, no writes occur for these pixels.
- Async reset during a write burst → bram_we=0 immediately, state IDLE, pix_count=0.
